// File: rtl/timer_mc_pkg.sv
// rtl/timer_mc_pkg.sv - register offsets, field types and helpers for timer_mc
package timer_mc_pkg;

  localparam int MAX_CH = 8;

  localparam logic [11:0] OFF_CR   = 12'h000;
  localparam logic [11:0] OFF_SR   = 12'h004;
  localparam logic [11:0] OFF_CNT  = 12'h008;
  localparam logic [11:0] OFF_PSC  = 12'h00C;
  localparam logic [11:0] OFF_ARR  = 12'h010;
  localparam logic [11:0] OFF_IER  = 12'h014;
  localparam logic [11:0] OFF_ISR  = 12'h018;
  localparam logic [11:0] OFF_CHMR = 12'h01C;
  localparam logic [11:0] OFF_CMPR = 12'h020;

  typedef struct packed {
    logic sngl;
    logic hlt;
    logic trg;
  } cr_t;

  typedef struct packed {
    logic act;
  } sr_t;

  typedef enum logic [1:0] {
    MODE_FLAG   = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_PWM    = 2'd2,
    MODE_LOW    = 2'd3
  } ch_mode_e;

  typedef logic [2*MAX_CH-1:0] chmr_t;

  // Sized for the maximum channel count; the top only writes the low NUM_CH slices.
  typedef struct packed {
    cr_t             cr;
    logic [MAX_CH:0] ier;
    logic [MAX_CH:0] isr;
    chmr_t           chmr;
  } ctrl_regs_t;

  function automatic ch_mode_e chmr_mode(input chmr_t chmr, input int ch);
    return ch_mode_e'(chmr[2*ch +: 2]);
  endfunction

  function automatic logic off_valid(input logic [11:0] off, input int num_ch);
    if (off[1:0] != 2'b00) return 1'b0;
    return off < (OFF_CMPR + 12'(4 * num_ch));
  endfunction

endpackage

// File: rtl/ibex_data_bus.sv
// rtl/ibex_data_bus.sv - Ibex-style data bus bundle with master and slave views
interface ibex_data_bus;
  logic        req;
  logic        gnt;
  logic        rvalid;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [6:0]  wdata_intg;
  logic [31:0] rdata;
  logic [6:0]  rdata_intg;
  logic        err;

  modport master (
    output req, we, be, addr, wdata, wdata_intg,
    input  gnt, rvalid, rdata, rdata_intg, err
  );

  modport slave (
    input  req, we, be, addr, wdata, wdata_intg,
    output gnt, rvalid, rdata, rdata_intg, err
  );
endinterface

// File: rtl/timer_mc_channel.sv
// rtl/timer_mc_channel.sv - one compare channel: match pulse plus flag/toggle/PWM output
module timer_mc_channel
  import timer_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] cmpr,
  input  ch_mode_e         mode,
  output logic             match,
  output logic             ch_out
);

  assign match = tick && (cnt == cmpr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_out <= 1'b0;
    end else begin
      case (mode)
        MODE_TOGGLE: if (match) ch_out <= ~ch_out;
        MODE_PWM:    ch_out <= (cnt < cmpr);
        default:     ch_out <= 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/timer_mc.sv
// rtl/timer_mc.sv - multi-channel prescaled auto-reload timer with Ibex data-bus registers
module timer_mc
  import timer_mc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PSC_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  ibex_data_bus.slave       data_bus,
  output logic              irq,
  output logic [NUM_CH-1:0] ch_out
);

  logic [11:0]      off;
  logic [31:0]      wdata;
  logic             valid;
  logic             wr;
  logic             wr_cr, wr_cnt, wr_psc, wr_arr, wr_ier, wr_isr, wr_chmr;
  cr_t              cr_w;
  ctrl_regs_t       regs;
  logic             act;
  logic [PSC_W-1:0] psc;
  logic [PSC_W-1:0] psc_cnt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] arr;
  logic [CNT_W-1:0] cmpr [NUM_CH];
  logic             tick;
  logic             wrap;
  logic [NUM_CH-1:0] match;
  logic [NUM_CH:0]  isr_set;
  logic [NUM_CH:0]  isr_clr;
  logic [31:0]      rd_val;
  logic             rvalid_q;
  logic             err_q;
  logic [31:0]      rdata_q;
  logic             unused_bits;

  assign off   = data_bus.addr[11:0];
  assign wdata = data_bus.wdata;
  assign valid = off_valid(off, NUM_CH);
  assign wr    = data_bus.req && data_bus.we && valid;

  assign wr_cr   = wr && (off == OFF_CR);
  assign wr_cnt  = wr && (off == OFF_CNT);
  assign wr_psc  = wr && (off == OFF_PSC);
  assign wr_arr  = wr && (off == OFF_ARR);
  assign wr_ier  = wr && (off == OFF_IER);
  assign wr_isr  = wr && (off == OFF_ISR);
  assign wr_chmr = wr && (off == OFF_CHMR);
  assign cr_w    = cr_t'(wdata[2:0]);

  // >= rather than == so a PSC lowered mid-period still wraps promptly.
  assign tick = act && (psc_cnt >= psc);
  assign wrap = tick && (cnt == arr);

  assign isr_set = {match, wrap};
  assign isr_clr = wr_isr ? wdata[NUM_CH:0] : '0;

  assign data_bus.gnt        = data_bus.req;
  assign data_bus.rvalid     = rvalid_q;
  assign data_bus.err        = err_q;
  assign data_bus.rdata      = rdata_q;
  assign data_bus.rdata_intg = '0;

  assign irq = |(regs.ier & regs.isr);

  assign unused_bits = ^{data_bus.be, data_bus.wdata_intg, data_bus.addr[31:12], wdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs    <= '0;
      act     <= 1'b0;
      psc     <= '0;
      psc_cnt <= '0;
      cnt     <= '0;
      arr     <= '0;
      for (int i = 0; i < NUM_CH; i++) cmpr[i] <= '0;
    end else begin
      if (wr_cr) begin
        regs.cr <= cr_w;
      end else begin
        regs.cr.trg <= 1'b0;
        regs.cr.hlt <= 1'b0;
      end

      if (wr_cr && cr_w.hlt)      act <= 1'b0;
      else if (wr_cr && cr_w.trg) act <= 1'b1;
      else if (wrap && regs.cr.sngl) act <= 1'b0;

      if (wr_cnt || (wr_cr && cr_w.trg) || tick) psc_cnt <= '0;
      else if (act)                              psc_cnt <= psc_cnt + 1'b1;

      if (wr_cnt)      cnt <= wdata[CNT_W-1:0];
      else if (wrap)   cnt <= '0;
      else if (tick)   cnt <= cnt + 1'b1;

      if (wr_psc)  psc <= wdata[PSC_W-1:0];
      if (wr_arr)  arr <= wdata[CNT_W-1:0];
      if (wr_ier)  regs.ier[NUM_CH:0] <= wdata[NUM_CH:0];
      if (wr_chmr) regs.chmr[2*NUM_CH-1:0] <= wdata[2*NUM_CH-1:0];
      // Hardware set takes priority over a simultaneous write-1-to-clear.
      regs.isr[NUM_CH:0] <= (regs.isr[NUM_CH:0] & ~isr_clr) | isr_set;

      for (int i = 0; i < NUM_CH; i++) begin
        if (wr && (off == OFF_CMPR + 12'(4 * i))) cmpr[i] <= wdata[CNT_W-1:0];
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_CR:   rd_val = 32'(regs.cr);
      OFF_SR:   rd_val = 32'(sr_t'(act));
      OFF_CNT:  rd_val = 32'(cnt);
      OFF_PSC:  rd_val = 32'(psc);
      OFF_ARR:  rd_val = 32'(arr);
      OFF_IER:  rd_val = 32'(regs.ier);
      OFF_ISR:  rd_val = 32'(regs.isr);
      OFF_CHMR: rd_val = 32'(regs.chmr);
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (off == OFF_CMPR + 12'(4 * i)) rd_val = 32'(cmpr[i]);
        end
      end
    endcase
  end

  // rdata captures the addressed register before any same-edge write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= data_bus.req;
      err_q    <= data_bus.req && !valid;
      rdata_q  <= (data_bus.req && valid) ? rd_val : '0;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_mc_channel #(.CNT_W(CNT_W)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .cnt   (cnt),
      .cmpr  (cmpr[g]),
      .mode  (chmr_mode(regs.chmr, g)),
      .match (match[g]),
      .ch_out(ch_out[g])
    );
  end

endmodule

// File: tb/tb_timer_mc.sv
// tb/tb_timer_mc.sv - self-checking bench for timer_mc
module tb_timer_mc;
  import timer_mc_pkg::*;

  localparam int NUM_CH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              irq;
  logic [NUM_CH-1:0] ch_out;
  int                cyc = 0;
  int                checks = 0;
  int                failures = 0;

  ibex_data_bus bus();

  timer_mc #(.NUM_CH(NUM_CH), .CNT_W(32), .PSC_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_bus(bus),
    .irq     (irq),
    .ch_out  (ch_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic we, input logic [11:0] a, input logic [31:0] d,
                              input logic er, input logic chk, input logic [31:0] rd);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = d; v.exp_err = er; v.chk_rd = chk; v.exp_rd = rd;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic xfer(input logic we, input logic [11:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output logic rv,
                      output logic gn, output int edge_n);
    @(negedge clk);
    bus.req = 1'b1; bus.we = we; bus.addr = {20'h0, a}; bus.wdata = d;
    #1 gn = bus.gnt;
    @(posedge clk);
    #1;
    edge_n = cyc;
    rd = bus.rdata; er = bus.err; rv = bus.rvalid;
    bus.req = 1'b0; bus.we = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, output int edge_n);
    logic [31:0] rd; logic er, rv, gn;
    xfer(1'b1, a, d, rd, er, rv, gn, edge_n);
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] data, output int edge_n);
    logic er, rv, gn;
    xfer(1'b0, a, 32'h0, data, er, rv, gn, edge_n);
  endtask

  // Reset is asserted between clock edges so outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    bus.req = 1'b0; bus.we = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_irq", 32'(irq), 0);
    check("rst_ch_out", 32'(ch_out), 0);
    check("rst_rvalid", 32'(bus.rvalid), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_rdata", bus.rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    logic er, rv, gn;
    int e, e_trg, r_cnt, r_isr, cnt_hi, toggles, k, k2, n;
    int p, a, c0;
    int cm [NUM_CH];
    logic prev;
    logic [31:0] exp_isr;

    bus.req = 1'b0; bus.we = 1'b0; bus.be = 4'hF; bus.addr = '0;
    bus.wdata = '0; bus.wdata_intg = '0;
    repeat (2) @(posedge clk);
    do_reset();

    add(0, OFF_CR,   0, 0, 1, 0);
    add(0, OFF_SR,   0, 0, 1, 0);
    add(0, OFF_CNT,  0, 0, 1, 0);
    add(0, OFF_ISR,  0, 0, 1, 0);
    add(1, OFF_PSC,  32'hFFFF1234, 0, 1, 0);
    add(0, OFF_PSC,  0, 0, 1, 32'h1234);
    add(1, OFF_ARR,  32'hDEADBEEF, 0, 1, 0);
    add(0, OFF_ARR,  0, 0, 1, 32'hDEADBEEF);
    add(1, OFF_CHMR, 32'hFFFFFFE4, 0, 1, 0);
    add(0, OFF_CHMR, 0, 0, 1, 32'hE4);
    add(1, OFF_IER,  32'hFFFFFFFF, 0, 1, 0);
    add(0, OFF_IER,  0, 0, 1, 32'h1F);
    add(1, 12'h02C,  32'h55, 0, 1, 0);
    add(0, 12'h02C,  0, 0, 1, 32'h55);
    add(0, 12'h030,  0, 1, 0, 0);
    add(1, 12'h0FC,  32'h1, 1, 0, 0);
    add(0, 12'h0FC,  0, 1, 0, 0);
    add(1, OFF_CNT,  32'h7, 0, 1, 0);
    add(0, OFF_CNT,  0, 0, 1, 32'h7);
    add(1, OFF_SR,   32'h1, 0, 1, 0);
    add(0, OFF_SR,   0, 0, 1, 0);
    add(1, OFF_CR,   32'h3, 0, 1, 0);
    add(0, OFF_SR,   0, 0, 1, 0);
    add(1, OFF_CR,   32'h4, 0, 1, 0);
    add(0, OFF_CR,   0, 0, 1, 32'h4);
    add(0, OFF_ISR,  0, 0, 1, 0);

    foreach (tbl[i]) begin
      xfer(tbl[i].we, tbl[i].addr, tbl[i].wdata, d, er, rv, gn, e);
      check($sformatf("tbl%0d_gnt", i), 32'(gn), 1);
      check($sformatf("tbl%0d_rvalid", i), 32'(rv), 1);
      check($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      if (tbl[i].chk_rd) check($sformatf("tbl%0d_rdata", i), d, tbl[i].exp_rd);
    end
    @(posedge clk); #1;
    check("idle_rvalid", 32'(bus.rvalid), 0);
    check("tbl_irq", 32'(irq), 0);

    // Prescaled count with overflow interrupt.
    do_reset();
    wr(OFF_PSC, 3, e); wr(OFF_ARR, 9, e); wr(OFF_IER, 1, e);
    wr(OFF_CR, 1, e_trg);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 39) check("psc_irq_before_wrap", 32'(irq), 0);
      if (c == 40) check("psc_irq_after_wrap", 32'(irq), 1);
    end
    rd(OFF_ISR, d, e);
    check("psc_isr", d, 32'h1F);
    rd(OFF_CNT, d, e);
    check("psc_cnt", d, 32'(((e - 1 - e_trg) / 4) % 10));

    // Single-shot stop at wrap.
    do_reset();
    wr(OFF_ARR, 5, e);
    wr(OFF_CR, 5, e_trg);
    repeat (5) @(posedge clk);
    rd(OFF_SR, d, e);
    check("sngl_act_before", d, 1);
    rd(OFF_SR, d, e);
    check("sngl_act_after", d, 0);
    rd(OFF_CNT, d, e);
    check("sngl_cnt", d, 0);
    repeat (5) @(posedge clk);
    rd(OFF_CNT, d, e);
    check("sngl_cnt_held", d, 0);
    rd(OFF_ISR, d, e);
    check("sngl_ovf", d & 32'h1, 1);

    // PWM duty on channel 2.
    do_reset();
    wr(OFF_ARR, 99, e); wr(OFF_CHMR, 32'h20, e); wr(12'h028, 25, e);
    wr(OFF_CR, 1, e);
    foreach (cm[i]) cm[i] = 0;
    for (int s = 0; s < 3; s++) begin
      if (s == 1) wr(12'h028, 0, e);
      if (s == 2) wr(12'h028, 200, e);
      repeat (2) @(posedge clk);
      cnt_hi = 0;
      for (int c = 0; c < 100; c++) begin
        @(posedge clk); #1;
        if (ch_out[2]) cnt_hi++;
      end
      check($sformatf("pwm_high_cycles_%0d", s), cnt_hi, (s == 0) ? 25 : (s == 1) ? 0 : 100);
    end

    // Toggle mode on channel 0, then switch back to flag-only.
    do_reset();
    wr(OFF_ARR, 7, e); wr(OFF_CHMR, 1, e); wr(12'h020, 3, e);
    wr(OFF_CR, 1, e);
    repeat (2) @(posedge clk); #1;
    prev = ch_out[0];
    toggles = 0;
    for (int c = 0; c < 32; c++) begin
      @(posedge clk); #1;
      if (ch_out[0] != prev) toggles++;
      prev = ch_out[0];
    end
    check("toggle_count", toggles, 4);
    rd(OFF_ISR, d, e);
    check("toggle_isr_cmp0", d & 32'h2, 32'h2);
    for (int c = 0; c < 16 && !ch_out[0]; c++) begin
      @(posedge clk); #1;
    end
    check("toggle_high_seen", 32'(ch_out[0]), 1);
    wr(OFF_CHMR, 0, e);
    @(posedge clk); #1;
    check("mode0_drives_low", 32'(ch_out[0]), 0);

    // Set beats simultaneous W1C, then a later W1C clears.
    do_reset();
    wr(OFF_ARR, 3, e); wr(OFF_IER, 1, e);
    wr(OFF_CR, 1, e_trg);
    repeat (3) @(posedge clk);
    wr(OFF_ISR, 1, e);
    check("setwin_edge", e - e_trg, 4);
    wr(OFF_CR, 2, e);
    rd(OFF_ISR, d, e);
    check("setwin_ovf", d & 32'h1, 1);
    check("setwin_irq", 32'(irq), 1);
    wr(OFF_ISR, 1, e);
    check("w1c_irq", 32'(irq), 0);
    rd(OFF_ISR, d, e);
    check("w1c_ovf", d & 32'h1, 0);

    // Randomised runs against an arithmetic model of ticks and wraps.
    do_reset();
    for (int it = 0; it < 30; it++) begin
      p  = $urandom_range(0, 3);
      a  = $urandom_range(0, 15);
      c0 = $urandom_range(0, a);
      foreach (cm[i]) cm[i] = $urandom_range(0, 15);
      wr(OFF_CR, 2, e);
      wr(OFF_CNT, c0, e); wr(OFF_PSC, p, e); wr(OFF_ARR, a, e);
      for (int i = 0; i < NUM_CH; i++) wr(OFF_CMPR + 12'(4 * i), cm[i], e);
      wr(OFF_ISR, 32'h1F, e);
      wr(OFF_CR, 1, e_trg);
      n = $urandom_range(0, 30);
      repeat (n) @(posedge clk);
      rd(OFF_CNT, d, r_cnt);
      k = (r_cnt - 1 - e_trg) / (p + 1);
      check($sformatf("rnd%0d_cnt p=%0d a=%0d c0=%0d", it, p, a, c0), d, 32'((c0 + k) % (a + 1)));
      rd(OFF_ISR, d, r_isr);
      k2 = (r_isr - 1 - e_trg) / (p + 1);
      exp_isr = ((c0 + k2) > a) ? 32'h1 : 32'h0;
      for (int i = 0; i < NUM_CH; i++)
        for (int j = 0; j < k2; j++)
          if (((c0 + j) % (a + 1)) == cm[i]) exp_isr[i+1] = 1'b1;
      check($sformatf("rnd%0d_isr", it), d, exp_isr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
